booth_pp_gen: RTL



---
 rtl/booth_pp_gen.sv | 98 +++++++++
 1 files changed

// File: rtl/booth_pp_gen.sv
// booth_pp_gen: two-stage radix-4 Booth encoder and partial-product generator.
// Stage 1 holds x with the encoded digits; stage 2 holds the packed rows and negate corrections.
module booth_pp_gen #(
  parameter int SIZE = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [SIZE-1:0]              in_x,
  input  logic [SIZE-1:0]              in_y,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [(SIZE/2)*(SIZE+1)-1:0] pp,
  output logic [SIZE-1:0]              cor
);
  localparam int ROWS = SIZE / 2;
  localparam int RW   = SIZE + 1;

  logic                s1_valid_reg;
  logic                s2_valid_reg;
  logic                s1_load;
  logic                s2_load;
  logic [SIZE-1:0]     x_reg;
  logic [ROWS-1:0]     sel1_reg, sel2_reg, neg_reg;
  logic [ROWS-1:0]     sel1_next, sel2_next, neg_next;
  logic [ROWS*RW-1:0]  pp_reg, pp_next;
  logic [SIZE-1:0]     cor_reg, cor_next;
  logic [SIZE:0]       y_ext;
  logic [RW-1:0]       x1_ext;
  logic [RW-1:0]       x2_ext;

  // Each stage advances when it is empty or the stage after it is moving.
  assign s2_load  = !s2_valid_reg || out_ready;
  assign s1_load  = !s1_valid_reg || s2_load;
  assign in_ready = s1_load;

  assign y_ext  = {in_y, 1'b0};
  assign x1_ext = {x_reg[SIZE-1], x_reg};
  assign x2_ext = {x_reg, 1'b0};

  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      logic [2:0]    trip;
      logic [RW-1:0] mag;

      // Triplet {y[2i+1], y[2i], y[2i-1]}; 000 and 111 both encode a plain zero.
      assign trip          = y_ext[2*gi +: 3];
      assign sel1_next[gi] = trip[1] ^ trip[0];
      assign sel2_next[gi] = (trip == 3'b011) || (trip == 3'b100);
      assign neg_next[gi]  = trip[2] && !(trip[1] && trip[0]);

      assign mag                   = sel2_reg[gi] ? x2_ext : (sel1_reg[gi] ? x1_ext : '0);
      assign pp_next[gi*RW +: RW]  = mag ^ {RW{neg_reg[gi]}};
      assign cor_next[2*gi]        = neg_reg[gi];
      assign cor_next[2*gi+1]      = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      x_reg        <= '0;
      sel1_reg     <= '0;
      sel2_reg     <= '0;
      neg_reg      <= '0;
    end else if (s1_load) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        x_reg    <= in_x;
        sel1_reg <= sel1_next;
        sel2_reg <= sel2_next;
        neg_reg  <= neg_next;
      end
    end
  end

  // Data registers only change on a real load so held results stay stable under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_reg <= 1'b0;
      pp_reg       <= '0;
      cor_reg      <= '0;
    end else if (s2_load) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        pp_reg  <= pp_next;
        cor_reg <= cor_next;
      end
    end
  end

  assign out_valid = s2_valid_reg;
  assign pp        = pp_reg;
  assign cor       = cor_reg;

endmodule
